// File: rtl/rtc_pkg.sv
// Shared types and command decode for the RTC / battery RAM controller.
// The command byte is decoded here so the top only sequences the transfer.
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXT   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } rtc_state_e;

  typedef enum logic [1:0] {
    TGT_SEC  = 2'd0,
    TGT_BRAM = 2'd1,
    TGT_TEST = 2'd2,
    TGT_WP   = 2'd3
  } rtc_target_e;

  localparam int CTRL_START = 7;
  localparam int CTRL_READ  = 6;
  localparam int CTRL_LAST  = 5;

  localparam logic [7:0] CMD_SEC_MASK    = 8'h73;
  localparam logic [7:0] CMD_SEC_VAL     = 8'h01;
  localparam logic [7:0] CMD_BRAM10_MASK = 8'h73;
  localparam logic [7:0] CMD_BRAM10_VAL  = 8'h21;
  localparam logic [7:0] CMD_BRAM_MASK   = 8'h43;
  localparam logic [7:0] CMD_BRAM_VAL    = 8'h41;
  localparam logic [7:0] CMD_EXT_MASK    = 8'h78;
  localparam logic [7:0] CMD_EXT_VAL     = 8'h38;
  localparam logic [7:0] CMD_TEST        = 8'h31;
  localparam logic [7:0] CMD_WP          = 8'h35;

  typedef struct packed {
    logic        valid;
    logic        ext;
    logic        rd;
    rtc_target_e tgt;
    logic [7:0]  addr;
  } rtc_cmd_t;

  // For EXT commands addr carries only the high three bits; the EXT byte fills the rest.
  function automatic rtc_cmd_t decode_cmd(input logic [7:0] b);
    rtc_cmd_t c;
    c.valid = 1'b0;
    c.ext   = 1'b0;
    c.rd    = b[7];
    c.tgt   = TGT_BRAM;
    c.addr  = 8'h00;
    if (b == CMD_TEST) begin
      c.valid = 1'b1;
      c.tgt   = TGT_TEST;
    end else if (b == CMD_WP) begin
      c.valid = 1'b1;
      c.tgt   = TGT_WP;
    end else if ((b & CMD_SEC_MASK) == CMD_SEC_VAL) begin
      c.valid = 1'b1;
      c.tgt   = TGT_SEC;
      c.addr  = {6'd0, b[3:2]};
    end else if ((b & CMD_BRAM10_MASK) == CMD_BRAM10_VAL) begin
      c.valid = 1'b1;
      c.addr  = {6'b000100, b[3:2]};
    end else if ((b & CMD_BRAM_MASK) == CMD_BRAM_VAL) begin
      c.valid = 1'b1;
      c.addr  = {4'd0, b[5:2]};
    end else if ((b & CMD_EXT_MASK) == CMD_EXT_VAL) begin
      c.ext   = 1'b1;
      c.addr  = {b[2:0], 5'd0};
    end
    return c;
  endfunction

endpackage

// File: rtl/rtc_bram_ctl_bram.sv
// 256x8 battery RAM: synchronous write, asynchronous read, contents survive reset.
module rtc_bram_256x8 (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem [256];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/rtc_bram_ctl.sv
// Clock chip behind the $C033 data / $C034 control registers: byte-serial
// command protocol, 32-bit seconds counter, write protect and 256-byte RAM.
module rtc_bram_ctl
  import rtc_pkg::*;
#(
  parameter int TICKS_PER_SEC = 2500000,
  parameter int BUSY_TICKS    = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cen,
  input  logic       strobe,
  input  logic       addr,
  input  logic       rw,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [1:0] dbg_state
);

  localparam int PW = $clog2(TICKS_PER_SEC + 1);
  localparam int CW = $clog2(BUSY_TICKS + 1);
  localparam logic [PW-1:0] PS_MAX   = PW'(TICKS_PER_SEC - 1);
  localparam logic [CW-1:0] BUSY_CNT = CW'(BUSY_TICKS);

  rtc_state_e  state;
  logic [7:0]  data_reg;
  logic [6:0]  ctrl;
  logic        busy;
  logic [CW-1:0] countdown;
  logic [PW-1:0] prescaler;
  logic [31:0] seconds;
  logic [31:0] sec_next;
  logic [7:0]  wp_reg;
  logic [7:0]  test_reg;
  logic        cmd_rd;
  rtc_target_e cmd_tgt;
  logic [7:0]  cmd_addr;
  rtc_cmd_t    cmd;
  logic [7:0]  bram_rdata;
  logic [7:0]  rd_byte;
  logic        wr_data, wr_ctrl, xfer, sec_tick, commit, commit_sec, bram_we;

  assign wr_data    = strobe && !rw && !addr;
  assign wr_ctrl    = strobe && !rw && addr;
  assign xfer       = busy && cen && (countdown == CW'(1));
  assign sec_tick   = cen && (prescaler == PS_MAX);
  assign commit     = xfer && !ctrl[CTRL_READ] && (state == ST_WDATA);
  assign commit_sec = commit && (cmd_tgt == TGT_SEC) && !wp_reg[7];
  assign bram_we    = commit && (cmd_tgt == TGT_BRAM) && !wp_reg[7];
  assign cmd        = decode_cmd(data_reg);
  assign dout       = addr ? {busy, ctrl} : data_reg;
  assign dbg_state  = state;

  rtc_bram_256x8 u_bram (
    .clk   (clk),
    .we    (bram_we),
    .addr  (cmd_addr),
    .wdata (data_reg),
    .rdata (bram_rdata)
  );

  always_comb begin
    rd_byte = wp_reg;
    case (cmd_tgt)
      TGT_SEC:  rd_byte = seconds[{cmd_addr[1:0], 3'b000} +: 8];
      TGT_BRAM: rd_byte = bram_rdata;
      TGT_TEST: rd_byte = test_reg;
      default:  rd_byte = wp_reg;
    endcase
  end

  // A committed byte write replaces the pre-increment value, so a coincident tick is lost.
  always_comb begin
    sec_next = seconds;
    if (sec_tick) sec_next = seconds + 32'd1;
    if (commit_sec) begin
      sec_next = seconds;
      sec_next[{cmd_addr[1:0], 3'b000} +: 8] = data_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      data_reg  <= 8'h00;
      ctrl      <= 7'h00;
      busy      <= 1'b0;
      countdown <= '0;
      prescaler <= '0;
      seconds   <= 32'h0;
      wp_reg    <= 8'h00;
      test_reg  <= 8'h00;
      cmd_rd    <= 1'b0;
      cmd_tgt   <= TGT_SEC;
      cmd_addr  <= 8'h00;
    end else begin
      seconds <= sec_next;
      if (cen) prescaler <= (prescaler == PS_MAX) ? '0 : prescaler + PW'(1);

      if (wr_data && !busy) data_reg <= din;

      if (wr_ctrl) begin
        if (din[CTRL_START]) begin
          if (!busy) begin
            ctrl      <= din[6:0];
            busy      <= 1'b1;
            countdown <= BUSY_CNT;
          end
        end else begin
          ctrl <= din[6:0];
          if (din[CTRL_LAST] && !busy) state <= ST_IDLE;
        end
      end

      if (busy && cen) begin
        countdown <= countdown - CW'(1);
        if (countdown == CW'(1)) begin
          busy <= 1'b0;
          if (ctrl[CTRL_READ]) begin
            if (state == ST_RDATA) begin
              data_reg <= rd_byte;
              state    <= ST_IDLE;
            end else begin
              data_reg <= 8'hFF;
            end
          end else begin
            case (state)
              ST_IDLE: begin
                cmd_rd   <= cmd.rd;
                cmd_tgt  <= cmd.tgt;
                cmd_addr <= cmd.addr;
                if (cmd.ext) state <= ST_EXT;
                else if (cmd.valid) state <= cmd.rd ? ST_RDATA : ST_WDATA;
              end
              ST_EXT: begin
                cmd_addr <= {cmd_addr[7:5], data_reg[6:2]};
                state    <= cmd_rd ? ST_RDATA : ST_WDATA;
              end
              ST_WDATA: begin
                if (cmd_tgt == TGT_WP)   wp_reg   <= data_reg;
                if (cmd_tgt == TGT_TEST) test_reg <= data_reg;
                state <= ST_IDLE;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule
